// File: rtl/update_bin_multi.sv
// Bin write-back sequencer: learnt clauses, mapped var states and level states
// are written back in three count-controlled phases, then a two-cycle drain.
module update_bin_multi #(
    parameter int NUM_CLAUSES_A_BIN      = 8,
    parameter int NUM_ORIG_CLAUSES       = 4,
    parameter int NUM_VARS_A_BIN         = 8,
    parameter int NUM_LVLS_A_BIN         = 8,
    parameter int WIDTH_CLAUSES          = 2 * NUM_VARS_A_BIN,
    parameter int WIDTH_VARS             = 12,
    parameter int WIDTH_LVL              = 16,
    parameter int WIDTH_BIN_ID           = 10,
    parameter int WIDTH_VAR_STATES       = 30,
    parameter int WIDTH_LVL_STATES       = 30,
    parameter int ADDR_WIDTH_CLAUSES     = 9,
    parameter int ADDR_WIDTH_VARS        = 9,
    parameter int ADDR_WIDTH_VARS_STATES = 9,
    parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start_update,
    input  logic [WIDTH_BIN_ID-1:0]                     cur_bin_num_i,
    input  logic [$clog2(NUM_CLAUSES_A_BIN+1)-1:0]      n_learnt_i,
    input  logic [$clog2(NUM_VARS_A_BIN+1)-1:0]         n_vars_i,
    input  logic [$clog2(NUM_LVLS_A_BIN+1)-1:0]         n_lvls_i,
    input  logic [WIDTH_LVL-1:0]                        base_lvl_i,
    output logic                                        apply_update_o,
    output logic                                        done_update,
    output logic [NUM_CLAUSES_A_BIN-1:0]                rd_carray_o,
    input  logic [WIDTH_CLAUSES-1:0]                    clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  var_state_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_i,
    output logic                                        ram_we_c_o,
    output logic [WIDTH_CLAUSES-1:0]                    ram_data_c_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0]               ram_addr_c_o,
    output logic [ADDR_WIDTH_VARS-1:0]                  ram_addr_v_o,
    input  logic [WIDTH_VARS-1:0]                       ram_data_v_i,
    output logic                                        ram_we_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                 ram_data_vs_o,
    output logic [ADDR_WIDTH_VARS_STATES-1:0]           ram_addr_vs_o,
    output logic                                        ram_we_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]                 ram_data_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0]           ram_addr_l_state_o
);

    localparam int unsigned NUM_LEARNT_MAX = NUM_CLAUSES_A_BIN - NUM_ORIG_CLAUSES;
    localparam int unsigned MAX_VL  = (NUM_VARS_A_BIN > NUM_LVLS_A_BIN) ? NUM_VARS_A_BIN : NUM_LVLS_A_BIN;
    localparam int unsigned MAX_ALL = (NUM_LEARNT_MAX > MAX_VL) ? NUM_LEARNT_MAX : MAX_VL;
    localparam int IDX_W = $clog2(MAX_ALL + 1);

    typedef enum logic [2:0] {IDLE, CLAUSE, VAR, LVL, DRAIN1, DRAIN2, DONE} state_t;

    state_t                       state, state_n;
    logic [IDX_W-1:0]             idx, idx_n;
    logic [IDX_W-1:0]             c_cnt, c_cnt_n, v_cnt, v_cnt_n, l_cnt, l_cnt_n;
    logic [IDX_W-1:0]             c_in, v_in, l_in;
    logic [ADDR_WIDTH_CLAUSES-1:0] cb, cb_n;
    logic [ADDR_WIDTH_VARS-1:0]   vb, vb_n;
    logic [WIDTH_LVL-1:0]         base, base_n;
    logic                         v_pend;
    logic [IDX_W-1:0]             v_slot;

    always_comb begin
        c_in = (32'(n_learnt_i) > NUM_LEARNT_MAX) ? IDX_W'(NUM_LEARNT_MAX) : IDX_W'(n_learnt_i);
        v_in = (32'(n_vars_i) > 32'(NUM_VARS_A_BIN)) ? IDX_W'(NUM_VARS_A_BIN) : IDX_W'(n_vars_i);
        l_in = (32'(n_lvls_i) > 32'(NUM_LVLS_A_BIN)) ? IDX_W'(NUM_LVLS_A_BIN) : IDX_W'(n_lvls_i);
    end

    // Phases with a zero count are skipped entirely.
    function automatic state_t after_clause(input logic [IDX_W-1:0] v, input logic [IDX_W-1:0] l);
        if (v != '0)      return VAR;
        else if (l != '0) return LVL;
        else              return DRAIN1;
    endfunction

    always_comb begin
        state_n = state;
        idx_n   = idx;
        c_cnt_n = c_cnt;
        v_cnt_n = v_cnt;
        l_cnt_n = l_cnt;
        cb_n    = cb;
        vb_n    = vb;
        base_n  = base;
        case (state)
            IDLE: begin
                if (start_update) begin
                    c_cnt_n = c_in;
                    v_cnt_n = v_in;
                    l_cnt_n = l_in;
                    cb_n    = ADDR_WIDTH_CLAUSES'(32'(cur_bin_num_i) * 32'(NUM_CLAUSES_A_BIN));
                    vb_n    = ADDR_WIDTH_VARS'(32'(cur_bin_num_i) * 32'(NUM_VARS_A_BIN));
                    base_n  = base_lvl_i;
                    idx_n   = '0;
                    state_n = (c_in != '0) ? CLAUSE : after_clause(v_in, l_in);
                end
            end
            CLAUSE: begin
                if (idx + 1'b1 == c_cnt) begin
                    idx_n   = '0;
                    state_n = after_clause(v_cnt, l_cnt);
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            VAR: begin
                if (idx + 1'b1 == v_cnt) begin
                    idx_n   = '0;
                    state_n = (l_cnt != '0) ? LVL : DRAIN1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            LVL: begin
                if (idx + 1'b1 == l_cnt) begin
                    idx_n   = '0;
                    state_n = DRAIN1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            DRAIN1:  state_n = DRAIN2;
            DRAIN2:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select/read-address outputs follow the next state so they are valid
    // for the whole cycle of the phase step they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            idx                <= '0;
            c_cnt              <= '0;
            v_cnt              <= '0;
            l_cnt              <= '0;
            cb                 <= '0;
            vb                 <= '0;
            base               <= '0;
            v_pend             <= 1'b0;
            v_slot             <= '0;
            apply_update_o     <= 1'b0;
            done_update        <= 1'b0;
            rd_carray_o        <= '0;
            ram_addr_v_o       <= '0;
            ram_we_c_o         <= 1'b0;
            ram_data_c_o       <= '0;
            ram_addr_c_o       <= '0;
            ram_we_vs_o        <= 1'b0;
            ram_data_vs_o      <= '0;
            ram_addr_vs_o      <= '0;
            ram_we_l_state_o   <= 1'b0;
            ram_data_l_state_o <= '0;
            ram_addr_l_state_o <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            c_cnt  <= c_cnt_n;
            v_cnt  <= v_cnt_n;
            l_cnt  <= l_cnt_n;
            cb     <= cb_n;
            vb     <= vb_n;
            base   <= base_n;

            apply_update_o <= (state_n != IDLE);
            done_update    <= (state_n == DONE);
            rd_carray_o    <= (state_n == CLAUSE)
                            ? (NUM_CLAUSES_A_BIN'(1) << (32'(NUM_ORIG_CLAUSES) + 32'(idx_n))) : '0;
            ram_addr_v_o   <= (state_n == VAR) ? ADDR_WIDTH_VARS'(32'(vb_n) + 32'(idx_n)) : '0;

            if (state == CLAUSE) begin
                ram_we_c_o   <= 1'b1;
                ram_data_c_o <= clause_i;
                ram_addr_c_o <= ADDR_WIDTH_CLAUSES'(32'(cb) + 32'(NUM_ORIG_CLAUSES) + 32'(idx));
            end else begin
                ram_we_c_o   <= 1'b0;
                ram_data_c_o <= '0;
                ram_addr_c_o <= '0;
            end

            // The map RAM answers one cycle after the address, hence one pending stage.
            v_pend <= (state == VAR);
            v_slot <= (state == VAR) ? idx : '0;
            if (v_pend && ram_data_v_i != '0) begin
                ram_we_vs_o   <= 1'b1;
                ram_data_vs_o <= var_state_i[32'(v_slot)*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
                ram_addr_vs_o <= ADDR_WIDTH_VARS_STATES'(ram_data_v_i);
            end else begin
                ram_we_vs_o   <= 1'b0;
                ram_data_vs_o <= '0;
                ram_addr_vs_o <= '0;
            end

            if (state == LVL) begin
                ram_we_l_state_o   <= 1'b1;
                ram_data_l_state_o <= lvl_states_i[32'(idx)*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
                ram_addr_l_state_o <= ADDR_WIDTH_LVLS_STATES'(32'(base) + 32'(idx));
            end else begin
                ram_we_l_state_o   <= 1'b0;
                ram_data_l_state_o <= '0;
                ram_addr_l_state_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_update_bin_multi.sv
// Self-checking bench for update_bin_multi: table vectors, random transactions,
// mid-operation restart pulse, back-to-back starts and asynchronous reset.
module tb_update_bin_multi;

    logic         clk;
    logic         rst_n;
    logic         start_update;
    logic [9:0]   cur_bin_num;
    logic [3:0]   n_learnt, n_vars, n_lvls;
    logic [15:0]  base_lvl;
    logic         apply_update, done_update;
    logic [7:0]   rd_carray;
    logic [15:0]  clause;
    logic [239:0] var_state, lvl_states;
    logic         we_c, we_vs, we_l;
    logic [15:0]  data_c;
    logic [8:0]   addr_c, addr_v, addr_vs, addr_l;
    logic [11:0]  data_v;
    logic [29:0]  data_vs, data_l;

    logic [15:0]  cl_tab [8];
    logic [11:0]  map_ram [512];

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    update_bin_multi dut (
        .clk(clk), .rst(rst_n), .start_update(start_update),
        .cur_bin_num_i(cur_bin_num), .n_learnt_i(n_learnt), .n_vars_i(n_vars),
        .n_lvls_i(n_lvls), .base_lvl_i(base_lvl),
        .apply_update_o(apply_update), .done_update(done_update),
        .rd_carray_o(rd_carray), .clause_i(clause),
        .var_state_i(var_state), .lvl_states_i(lvl_states),
        .ram_we_c_o(we_c), .ram_data_c_o(data_c), .ram_addr_c_o(addr_c),
        .ram_addr_v_o(addr_v), .ram_data_v_i(data_v),
        .ram_we_vs_o(we_vs), .ram_data_vs_o(data_vs), .ram_addr_vs_o(addr_vs),
        .ram_we_l_state_o(we_l), .ram_data_l_state_o(data_l), .ram_addr_l_state_o(addr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine clause mux and synchronous var-bin map RAM
    always_comb begin
        clause = '0;
        for (int j = 0; j < 8; j++)
            if (rd_carray[j]) clause = cl_tab[j];
    end

    always @(posedge clk) data_v <= map_ram[addr_v];

    typedef struct {
        int bin, nl, nv, nlv, base;
        logic [7:0] zmask;
        int pulse, gap;
        int exp_done, exp_nc, exp_nv, exp_nl;
    } vec_t;

    typedef struct {
        int cyc;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s txn %0d: got %0h expected %0h", name, txn_no, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{apply_update, done_update, rd_carray, we_c, data_c, addr_c, addr_v,
                 we_vs, data_vs, addr_vs, we_l, data_l, addr_l};
    endfunction

    task automatic port_step(input string nm, input int cur, input logic we,
                             input logic [63:0] addr, input logic [63:0] data,
                             input bit have, input wr_t f, output bit popped);
        bit expw;
        expw = have && (f.cyc == cur);
        chk({nm, "_we"}, 64'(we), 64'(expw));
        if (expw) begin
            chk({nm, "_addr"}, addr, f.addr);
            chk({nm, "_data"}, data, f.data);
        end else begin
            chk({nm, "_idle_zero"}, addr | data, 64'd0);
        end
        popped = expw;
    endtask

    task automatic run_txn(input vec_t v, input int rst_cyc);
        wr_t qc[$], qv[$], ql[$];
        wr_t f, dummy;
        int C, V, L, N, nc, nvw, nlw, done_cyc;
        bit p, aborted;
        logic [11:0] id;
        logic [29:0] t30;
        dummy = '{0, 64'd0, 64'd0};
        txn_no++;
        nc = 0; nvw = 0; nlw = 0; done_cyc = 0; aborted = 0;

        for (int j = 0; j < 8; j++) cl_tab[j] = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            t30 = 30'($urandom); var_state[k*30 +: 30] = t30;
            t30 = 30'($urandom); lvl_states[k*30 +: 30] = t30;
            id = v.zmask[k] ? 12'd0 : 12'($urandom_range(1, 4095));
            map_ram[(v.bin*8 + k) % 512] = id;
        end

        // Reference: clamped counts, then the write lists with their cycles
        C = (v.nl  < 4) ? v.nl  : 4;
        V = (v.nv  < 8) ? v.nv  : 8;
        L = (v.nlv < 8) ? v.nlv : 8;
        N = C + V + L + 3;
        for (int k = 0; k < C; k++)
            qc.push_back('{2 + k, 64'((v.bin*8 + 4 + k) % 512), 64'(cl_tab[4 + k])});
        for (int k = 0; k < V; k++) begin
            id = map_ram[(v.bin*8 + k) % 512];
            if (id != 0) qv.push_back('{C + 3 + k, 64'(id % 512), 64'(var_state[k*30 +: 30])});
        end
        for (int k = 0; k < L; k++)
            ql.push_back('{C + V + 2 + k, 64'((v.base + k) % 512), 64'(lvl_states[k*30 +: 30])});

        cur_bin_num = 10'(v.bin); n_learnt = 4'(v.nl); n_vars = 4'(v.nv);
        n_lvls = 4'(v.nlv); base_lvl = 16'(v.base);
        start_update = 1'b1;
        @(posedge clk);
        #1 start_update = 1'b0;
        cur_bin_num = 10'($urandom); n_learnt = 4'($urandom); n_vars = 4'($urandom);
        n_lvls = 4'($urandom); base_lvl = 16'($urandom);

        for (int cur = 1; cur <= N + 1; cur++) begin
            @(negedge clk);
            start_update = 1'b0;
            chk("apply", 64'(apply_update), 64'(cur <= N));
            chk("done", 64'(done_update), 64'(cur == N));
            if (done_update && done_cyc == 0) done_cyc = cur;
            chk("rd_carray", 64'(rd_carray), (cur <= C) ? (64'd1 << (4 + cur - 1)) : 64'd0);
            if (we_c) nc++;
            if (we_vs) nvw++;
            if (we_l) nlw++;
            f = (qc.size() > 0) ? qc[0] : dummy;
            port_step("clause", cur, we_c, 64'(addr_c), 64'(data_c), qc.size() > 0, f, p);
            if (p) void'(qc.pop_front());
            f = (qv.size() > 0) ? qv[0] : dummy;
            port_step("varst", cur, we_vs, 64'(addr_vs), 64'(data_vs), qv.size() > 0, f, p);
            if (p) void'(qv.pop_front());
            f = (ql.size() > 0) ? ql[0] : dummy;
            port_step("lvlst", cur, we_l, 64'(addr_l), 64'(data_l), ql.size() > 0, f, p);
            if (p) void'(ql.pop_front());
            if (cur == v.pulse) start_update = 1'b1;
            if (cur == rst_cyc) begin
                #2 rst_n = 1'b0;
                #1 chk("rst_async_zero", 64'(any_out()), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold_zero", 64'(any_out()), 64'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_idle", 64'(any_out()), 64'd0);
                aborted = 1;
                break;
            end
        end

        if (!aborted) begin
            chk("clause_missing", 64'(qc.size()), 64'd0);
            chk("varst_missing", 64'(qv.size()), 64'd0);
            chk("lvlst_missing", 64'(ql.size()), 64'd0);
            if (v.exp_done >= 0) begin
                chk("tbl_done_cycle", 64'(done_cyc), 64'(v.exp_done));
                chk("tbl_n_clause", 64'(nc), 64'(v.exp_nc));
                chk("tbl_n_varst", 64'(nvw), 64'(v.exp_nv));
                chk("tbl_n_lvlst", 64'(nlw), 64'(v.exp_nl));
            end
        end
        repeat (v.gap) @(negedge clk);
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) map_ram[i] = '0;
        for (int j = 0; j < 8; j++) cl_tab[j] = '0;
        rst_n = 1'b0; start_update = 1'b0;
        cur_bin_num = '0; n_learnt = '0; n_vars = '0; n_lvls = '0; base_lvl = '0;
        var_state = '0; lvl_states = '0;

        //        bin  nl  nv nlv base  zmask       pulse gap done nc nv nl
        tbl[0] = '{2,    4,  8,  8,  5, 8'h00,       8,   0,  23, 4, 8, 8};
        tbl[1] = '{5,    0,  0,  0, 100, 8'h00,      0,   1,   3, 0, 0, 0};
        tbl[2] = '{7,    2,  8,  3, 40, 8'b0100_1000, 0,  0,  16, 2, 6, 3};
        tbl[3] = '{1,    7,  3,  8, 510, 8'h00,      0,   2,  18, 4, 3, 8};
        tbl[4] = '{1023, 15, 15, 15, 65535, 8'h00,   0,   0,  23, 4, 8, 8};
        tbl[5] = '{0,    0,  0,  1,  0, 8'h00,       0,   1,   4, 0, 0, 1};

        #3;
        chk("reset_state", 64'(any_out()), 64'd0);
        @(negedge clk);
        chk("reset_state_clk", 64'(any_out()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], 0);

        for (int i = 0; i < 25; i++) begin
            rv = '{$urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 65535), 8'($urandom),
                   $urandom_range(0, 6), $urandom_range(0, 2), -1, 0, 0, 0};
            run_txn(rv, 0);
        end

        // Reset asserted in the LVL phase, then a clean update afterwards
        run_txn(tbl[0], 15);
        run_txn(tbl[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
